// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a latched PAT_W-bit pattern out MSB-first, repeat_n times.
// Optional inter-frame idle gap is built only when SEQ_GEN_GAP_EN is defined.
module seq_pattern_gen #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter int GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             w,
    output logic             w_valid,
    output logic             frame_sof,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    if (PAT_W < 2 || GAP_LEN < 1) begin : g_param_check
        $error("seq_pattern_gen: PAT_W must be >= 2 and GAP_LEN >= 1");
    end

`ifdef SEQ_GEN_GAP_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    localparam int GAP_W = $clog2(GAP_LEN + 1);
    logic [GAP_W-1:0] gapcnt;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state;
    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] shreg;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] rem;

    // shreg holds the bits still to come; w already carries the current bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pat       <= '0;
            shreg     <= '0;
            idx       <= '0;
            rem       <= '0;
            w         <= 1'b0;
            w_valid   <= 1'b0;
            frame_sof <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
            gapcnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat <= pattern;
                        rem <= repeat_n;
                        if (repeat_n != '0) begin
                            state     <= SHIFT;
                            shreg     <= {pattern[PAT_W-2:0], 1'b0};
                            idx       <= LAST_IDX;
                            w         <= pattern[PAT_W-1];
                            w_valid   <= 1'b1;
                            frame_sof <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    if (idx != '0) begin
                        shreg     <= shreg << 1;
                        w         <= shreg[PAT_W-1];
                        idx       <= idx - 1'b1;
                        frame_sof <= 1'b0;
                    end else begin
                        rem <= rem - 1'b1;
                        if (rem == CNT_W'(1)) begin
                            state     <= DONE;
                            w         <= 1'b0;
                            w_valid   <= 1'b0;
                            frame_sof <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
`ifdef SEQ_GEN_GAP_EN
                            state     <= GAP;
                            gapcnt    <= GAP_W'(GAP_LEN - 1);
                            w         <= 1'b0;
                            w_valid   <= 1'b0;
                            frame_sof <= 1'b0;
`else
                            shreg     <= {pat[PAT_W-2:0], 1'b0};
                            idx       <= LAST_IDX;
                            w         <= pat[PAT_W-1];
                            frame_sof <= 1'b1;
`endif
                        end
                    end
                end

`ifdef SEQ_GEN_GAP_EN
                GAP: begin
                    if (gapcnt == '0) begin
                        state     <= SHIFT;
                        shreg     <= {pat[PAT_W-2:0], 1'b0};
                        idx       <= LAST_IDX;
                        w         <= pat[PAT_W-1];
                        w_valid   <= 1'b1;
                        frame_sof <= 1'b1;
                    end else begin
                        gapcnt <= gapcnt - 1'b1;
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state     <= IDLE;
                    w         <= 1'b0;
                    w_valid   <= 1'b0;
                    frame_sof <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: stimulus pushes per-cycle expectations, a monitor pops them.
// Expectation strings: H/L = first bit 1/0, 1/0 = later bits, g = gap cycle, D = done cycle.
module tb_seq_pattern_gen;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int GAP_LEN = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             w;
    logic             w_valid;
    logic             frame_sof;
    logic             busy;
    logic             done;

    typedef struct {
        int unsigned cyc;
        logic        v;
        logic        w;
        logic        sof;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc    = 0;

    seq_pattern_gen #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .GAP_LEN (GAP_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pattern   (pattern),
        .repeat_n  (repeat_n),
        .w         (w),
        .w_valid   (w_valid),
        .frame_sof (frame_sof),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pops one expectation for every cycle in which the DUT shows activity.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (w_valid || done || busy)) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_output cyc=%0d got v=%b w=%b sof=%b busy=%b done=%b, required no activity",
                             cyc, w_valid, w, frame_sof, busy, done);
                end else begin
                    e = expq.pop_front();
                    if (e.cyc != cyc || e.v !== w_valid || e.w !== w || e.sof !== frame_sof ||
                        e.busy !== busy || e.done !== done) begin
                        errors++;
                        $display("[TB] FAIL output_cycle got cyc=%0d v=%b w=%b sof=%b busy=%b done=%b, required cyc=%0d v=%b w=%b sof=%b busy=%b done=%b",
                                 cyc, w_valid, w, frame_sof, busy, done,
                                 e.cyc, e.v, e.w, e.sof, e.busy, e.done);
                    end
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expv);
        logic [4:0] got;
        got = {w, w_valid, frame_sof, busy, done};
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s got {w,valid,sof,busy,done}=%b, required %b", name, got, expv);
        end
    endtask

    task automatic pushExp(input int unsigned c, input byte ch);
        exp_t e;
        e.cyc = c;
        e.v = 1'b0; e.w = 1'b0; e.sof = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        case (ch)
            "H": begin e.v = 1'b1; e.w = 1'b1; e.sof = 1'b1; e.busy = 1'b1; end
            "L": begin e.v = 1'b1; e.w = 1'b0; e.sof = 1'b1; e.busy = 1'b1; end
            "1": begin e.v = 1'b1; e.w = 1'b1; e.busy = 1'b1; end
            "0": begin e.v = 1'b1; e.w = 1'b0; e.busy = 1'b1; end
            "g": begin e.busy = 1'b1; end
            default: begin e.done = 1'b1; end
        endcase
        expq.push_back(e);
    endtask

    // Starts one transfer; poke >= 0 re-asserts start during that cycle of the transfer.
    task automatic applyStimulus(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] n,
                                 input string expStr, input int poke);
        int unsigned e0;
        @(negedge clk);
        pattern  = pat;
        repeat_n = n;
        start    = 1'b1;
        e0       = cyc + 1;
        for (int i = 0; i < expStr.len(); i++) pushExp(e0 + i, expStr[i]);
        @(posedge clk);
        #1;
        start    = 1'b0;
        pattern  = ~pat;
        repeat_n = n + 8'd5;
        for (int k = 0; k < 200 && expq.size() != 0; k++) begin
            @(negedge clk);
            #1;
            start = (poke >= 0 && cyc == e0 + poke) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain_timeout pending=%0d, required 0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        rst      = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        repeat_n = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_state", 5'b00000);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_idle", 5'b00000);
        #1;
        rst = 1'b0;

        $display("[TB] single frame, stray start in cycle 2");
        applyStimulus(4'b1011, 8'd1, "H011D", 2);

        $display("[TB] two frames, stray start during done");
`ifdef SEQ_GEN_GAP_EN
        applyStimulus(4'b0001, 8'd2, "L001ggL001D", 10);
`else
        applyStimulus(4'b0001, 8'd2, "L001L001D", 8);
`endif

        $display("[TB] three frames");
`ifdef SEQ_GEN_GAP_EN
        applyStimulus(4'b1011, 8'd3, "H011ggH011ggH011D", -1);
`else
        applyStimulus(4'b1011, 8'd3, "H011H011H011D", -1);
`endif

        $display("[TB] zero frames");
        applyStimulus(4'b1111, 8'd0, "D", -1);

        $display("[TB] reset during transfer");
        @(negedge clk);
        pattern  = 4'b1011;
        repeat_n = 8'd1;
        start    = 1'b1;
        pushExp(cyc + 1, "H");
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_mid_transfer", 5'b00000);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL pre_reset_bit pending=%0d, required 0", expq.size());
            expq.delete();
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        applyStimulus(4'b0110, 8'd1, "L110D", -1);

        $display("[TB] two frames of 1011");
`ifdef SEQ_GEN_GAP_EN
        applyStimulus(4'b1011, 8'd2, "H011ggH011D", -1);
`else
        applyStimulus(4'b1011, 8'd2, "H011H011D", -1);
`endif

        repeat (4) @(negedge clk);
        #1;
        checkOutput("final_idle", 5'b00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
